// File: rtl/letc_pkg.sv
// Shared types for the LETC core control path: FSM states, trap causes, PC select
// and the timeout counter width helper.
package letc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5,
        HALT   = 3'd6
    } core_state_e;

    typedef enum logic [1:0] {
        ILLEGAL       = 2'd0,
        ACCESS_FAULT  = 2'd1,
        FETCH_TIMEOUT = 2'd2,
        MEM_TIMEOUT   = 2'd3
    } trap_cause_e;

    typedef enum logic [1:0] {
        PC_NEXT = 2'd0,
        PC_TRAP = 2'd1
    } pc_sel_e;

    localparam int STATE_W = $bits(core_state_e);
    localparam int TC_W    = $bits(trap_cause_e);

    // A disabled timeout still needs a one-bit counter to keep the vector legal.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/core_wait_timer.sv
// Saturating handshake wait counter; flags expiry once the count reaches TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 pins the count at zero and never expires.
module core_wait_timer
    import letc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            TW    = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr || (TIMEOUT_CYCLES == 0)) begin
            r_count <= '0;
        end else if (en && (r_count != LIMIT)) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (r_count == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the LETC core: fetch, decode, memory access, writeback,
// trap and debug halt, with req/ack handshakes to the fetch and LSU ports.
module core_sequencer
    import letc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CAUSE_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               fetch_req,
    input  logic               fetch_ack,
    input  logic               dec_illegal,
    input  logic               dec_is_load,
    input  logic               dec_is_store,
    input  logic               dec_writes_rd,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    input  logic               mem_err,
    output logic               ir_we,
    output logic               rf_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               retire,
    output logic               trap_valid,
    output logic [CAUSE_W-1:0] trap_cause,
    input  logic               halt_req,
    input  logic               resume_req,
    output logic               halted,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [STATE_W-1:0] S_IDLE   = IDLE;
    localparam logic [STATE_W-1:0] S_FETCH  = FETCH;
    localparam logic [STATE_W-1:0] S_DECODE = DECODE;
    localparam logic [STATE_W-1:0] S_MEM    = MEM;
    localparam logic [STATE_W-1:0] S_WB     = WB;
    localparam logic [STATE_W-1:0] S_TRAP   = TRAP;
    localparam logic [STATE_W-1:0] S_HALT   = HALT;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic               r_halt_pend;
    logic               r_mem_we;
    logic [TC_W-1:0]    r_trap_cause;
    logic [TC_W-1:0]    w_cause_next;
    logic               w_cause_load;

    logic w_in_fetch;
    logic w_in_mem;
    logic w_in_wb;
    logic w_in_trap;
    logic w_ack;
    logic w_expired;
    logic w_timeout;

    assign w_in_fetch = (r_state == S_FETCH);
    assign w_in_mem   = (r_state == S_MEM);
    assign w_in_wb    = (r_state == S_WB);
    assign w_in_trap  = (r_state == S_TRAP);
    assign w_ack      = (w_in_fetch && fetch_ack) || (w_in_mem && mem_ack);

    // FETCH and MEM are never adjacent, so holding the timer clear outside them
    // guarantees it starts from zero on every new handshake.
    core_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!(w_in_fetch || w_in_mem)),
        .en     (!w_ack),
        .expired(w_expired)
    );

    // An ack arriving on the expiry cycle takes precedence over the timeout.
    assign w_timeout = w_expired && !w_ack && (w_in_fetch || w_in_mem);

    always_comb begin
        w_state_next = S_IDLE;
        w_cause_load = 1'b0;
        w_cause_next = ILLEGAL;
        case (r_state)
            S_IDLE: begin
                w_state_next = (halt_req || r_halt_pend) ? S_HALT : S_FETCH;
            end
            S_FETCH: begin
                if (fetch_ack) begin
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_TRAP;
                    w_cause_load = 1'b1;
                    w_cause_next = FETCH_TIMEOUT;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    w_state_next = S_TRAP;
                    w_cause_load = 1'b1;
                    w_cause_next = ILLEGAL;
                end else if (dec_is_load || dec_is_store) begin
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack && mem_err) begin
                    w_state_next = S_TRAP;
                    w_cause_load = 1'b1;
                    w_cause_next = ACCESS_FAULT;
                end else if (mem_ack) begin
                    w_state_next = S_WB;
                end else if (w_timeout) begin
                    w_state_next = S_TRAP;
                    w_cause_load = 1'b1;
                    w_cause_next = MEM_TIMEOUT;
                end else begin
                    w_state_next = S_MEM;
                end
            end
            S_WB, S_TRAP: begin
                w_state_next = r_halt_pend ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                w_state_next = (resume_req && !halt_req) ? S_FETCH : S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_halt_pend  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_trap_cause <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_HALT) && (w_state_next == S_FETCH)) begin
                r_halt_pend <= 1'b0;
            end else if (halt_req) begin
                r_halt_pend <= 1'b1;
            end
            if (r_state == S_DECODE) begin
                r_mem_we <= dec_is_store;
            end
            if (w_cause_load) begin
                r_trap_cause <= w_cause_next;
            end
        end
    end

    assign fetch_req  = w_in_fetch;
    assign ir_we      = w_in_fetch && fetch_ack;
    assign mem_req    = w_in_mem;
    assign mem_we     = w_in_mem && r_mem_we;
    assign rf_we      = w_in_wb && dec_writes_rd && !r_mem_we;
    assign pc_we      = w_in_wb || w_in_trap;
    assign pc_sel     = w_in_trap ? PC_TRAP : PC_NEXT;
    assign retire     = w_in_wb;
    assign trap_valid = w_in_trap;
    assign trap_cause = w_in_trap ? CAUSE_W'(r_trap_cause) : '0;
    assign halted     = (r_state == S_HALT);
    assign state_o    = r_state;

endmodule
